branch_resolve_ctrl: RTL and testbench

- D-stage sequencer for the branch comparator.
- Detects a branch in D and holds the pipeline (stall) until both compare operands are forwarded-ready.
- When operands are ready, drives the compare opcode to the comparator and samples its condition in the same cycle.
- Emits the PC redirect, keeps branch/stall performance counters, and raises a sticky watchdog error if a stall never clears.

---
 rtl/branch_resolve_ctrl.sv | 126 ++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// D-stage branch sequencer: stalls until both compare operands are ready, then drives the
// comparator opcode, emits the PC redirect and keeps branch/stall statistics plus a watchdog.
module branch_resolve_ctrl #(
    parameter int unsigned PERF_W    = 32,
    parameter int unsigned MAX_STALL = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [2:0]        d_cmp_op,
    input  logic [31:0]       d_pc,
    input  logic [15:0]       d_imm16,
    input  logic              rs_ready,
    input  logic              rt_ready,
    input  logic              flush,
    input  logic              cmp_cond,
    output logic [2:0]        cmp_op,
    output logic              stall,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic [PERF_W-1:0] br_cnt,
    output logic [PERF_W-1:0] taken_cnt,
    output logic [PERF_W-1:0] stall_cnt,
    output logic              hang_err
);

    localparam logic [7:0] MaxStallW = 8'(MAX_STALL);
    localparam logic [7:0] WcntMax   = 8'hFF;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic              hang_q, hang_d;
    logic [PERF_W-1:0] br_q, br_d;
    logic [PERF_W-1:0] taken_q, taken_d;
    logic [PERF_W-1:0] stall_q, stall_d;

    logic is_br;
    logic ready;
    logic resolve;

    // flush folds into is_br, so a flushed cycle can never stall, resolve or count
    assign is_br   = d_valid && (d_cmp_op != 3'b000) && !flush;
    assign ready   = rs_ready && rt_ready;
    assign resolve = is_br && ready;

    always_comb begin
        cmp_op      = 3'b000;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = d_pc + 32'd4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
        if (resolve) begin
            cmp_op   = d_cmp_op;
            redirect = cmp_cond;
        end
        if (is_br && !ready) begin
            stall = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            StIdle: begin
                if (is_br && !ready) begin
                    state_d = StWait;
                    wcnt_d  = 8'd1;
                end else begin
                    wcnt_d = 8'd0;
                end
            end
            StWait: begin
                if (!is_br || ready) begin
                    state_d = StIdle;
                    wcnt_d  = 8'd0;
                end else if (wcnt_q != WcntMax) begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                wcnt_d  = 8'd0;
            end
        endcase
    end

    // wcnt_d counts this stall cycle, so the flag rises on the edge ending stall cycle MAX_STALL
    always_comb begin
        hang_d = hang_q;
        if (stall && (wcnt_d >= MaxStallW)) begin
            hang_d = 1'b1;
        end
    end

    always_comb begin
        br_d    = br_q + PERF_W'(resolve);
        taken_d = taken_q + PERF_W'(redirect);
        stall_d = stall_q + PERF_W'(stall);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            wcnt_q  <= 8'd0;
            hang_q  <= 1'b0;
            br_q    <= '0;
            taken_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            hang_q  <= hang_d;
            br_q    <= br_d;
            taken_q <= taken_d;
            stall_q <= stall_d;
        end
    end

    assign br_cnt    = br_q;
    assign taken_cnt = taken_q;
    assign stall_cnt = stall_q;
    assign hang_err  = hang_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: vector table for single-cycle behaviour plus
// sequences for operand waits, flush, watchdog, mid-stall reset and counter wrap.
module tb_branch_resolve_ctrl;

    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          d_valid;
    logic [2:0]    d_cmp_op;
    logic [31:0]   d_pc;
    logic [15:0]   d_imm16;
    logic          rs_ready;
    logic          rt_ready;
    logic          flush;
    logic          cmp_cond;
    logic [2:0]    cmp_op;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [PW-1:0] br_cnt;
    logic [PW-1:0] taken_cnt;
    logic [PW-1:0] stall_cnt;
    logic          hang_err;

    int total = 0;
    int bad   = 0;

    logic [PW-1:0] m_br, m_tk, m_st;

    branch_resolve_ctrl #(
        .PERF_W   (PW),
        .MAX_STALL(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_cmp_op   (d_cmp_op),
        .d_pc       (d_pc),
        .d_imm16    (d_imm16),
        .rs_ready   (rs_ready),
        .rt_ready   (rt_ready),
        .flush      (flush),
        .cmp_cond   (cmp_cond),
        .cmp_op     (cmp_op),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .br_cnt     (br_cnt),
        .taken_cnt  (taken_cnt),
        .stall_cnt  (stall_cnt),
        .hang_err   (hang_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [31:0] pc;
        logic [15:0] imm;
        logic        rs;
        logic        rt;
        logic        fl;
        logic        cond;
        logic        e_stall;
        logic [2:0]  e_op;
        logic        e_red;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] pc,
                         input logic [15:0] imm, input logic rs, input logic rt,
                         input logic fl, input logic cond);
        d_valid  = v;
        d_cmp_op = op;
        d_pc     = pc;
        d_imm16  = imm;
        rs_ready = rs;
        rt_ready = rt;
        flush    = fl;
        cmp_cond = cond;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 32'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        m_br = '0;
        m_tk = '0;
        m_st = '0;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, ".br_cnt"}, 32'(br_cnt), 32'(m_br));
        check({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(m_tk));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_st));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //        v  op  pc            imm      rs rt fl cond  stall op red rpc
        vecs[0] = '{1, 3'd1, 32'h0000_3000, 16'h0004, 1, 1, 0, 1, 0, 3'd1, 1, 32'h0000_3014};
        vecs[1] = '{1, 3'd2, 32'h0000_3010, 16'hFFFC, 1, 1, 0, 0, 0, 3'd2, 0, 32'h0000_3004};
        vecs[2] = '{1, 3'd3, 32'h0000_1000, 16'h0010, 0, 1, 0, 1, 1, 3'd0, 0, 32'h0000_1044};
        vecs[3] = '{1, 3'd1, 32'h0000_2000, 16'h0000, 1, 1, 1, 1, 0, 3'd0, 0, 32'h0000_2004};
        vecs[4] = '{0, 3'd5, 32'h0000_0000, 16'h8000, 1, 1, 0, 1, 0, 3'd0, 0, 32'hFFFE_0004};
        vecs[5] = '{1, 3'd0, 32'hFFFF_FFFC, 16'h7FFF, 1, 1, 0, 1, 0, 3'd0, 0, 32'h0001_FFFC};
        vecs[6] = '{1, 3'd7, 32'hFFFF_FFF0, 16'h0004, 1, 1, 0, 1, 0, 3'd7, 1, 32'h0000_0004};
        vecs[7] = '{1, 3'd4, 32'h0000_4000, 16'h0001, 1, 0, 1, 1, 0, 3'd0, 0, 32'h0000_4008};

        do_reset();
        tick();
        do_reset();
        #1;
        check("rst.br_cnt", 32'(br_cnt), 32'h0);
        check("rst.taken_cnt", 32'(taken_cnt), 32'h0);
        check("rst.stall_cnt", 32'(stall_cnt), 32'h0);
        check("rst.hang_err", 32'(hang_err), 32'h0);
        check("rst.stall", 32'(stall), 32'h0);
        check("rst.redirect", 32'(redirect), 32'h0);
        check("rst.cmp_op", 32'(cmp_op), 32'h0);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].pc, vecs[i].imm,
                  vecs[i].rs, vecs[i].rt, vecs[i].fl, vecs[i].cond);
            #1;
            check($sformatf("vec%0d.stall", i), 32'(stall), 32'(vecs[i].e_stall));
            check($sformatf("vec%0d.cmp_op", i), 32'(cmp_op), 32'(vecs[i].e_op));
            check($sformatf("vec%0d.redirect", i), 32'(redirect), 32'(vecs[i].e_red));
            check($sformatf("vec%0d.redirect_pc", i), redirect_pc, vecs[i].e_rpc);
            m_br = m_br + PW'(vecs[i].e_op != 3'd0);
            m_tk = m_tk + PW'(vecs[i].e_red);
            m_st = m_st + PW'(vecs[i].e_stall);
            tick();
            idle();
            check_cnts($sformatf("vec%0d", i));
            tick();
        end

        // operand hazard: two wait cycles then resolve taken
        do_reset();
        drive(1'b1, 3'd1, 32'h0000_3000, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("haz%0d.stall", k), 32'(stall), 32'h1);
            check($sformatf("haz%0d.cmp_op", k), 32'(cmp_op), 32'h0);
            check($sformatf("haz%0d.redirect", k), 32'(redirect), 32'h0);
            tick();
        end
        rt_ready = 1'b1;
        #1;
        check("haz.res.stall", 32'(stall), 32'h0);
        check("haz.res.redirect", 32'(redirect), 32'h1);
        check("haz.res.cmp_op", 32'(cmp_op), 32'h1);
        tick();
        idle();
        m_br = 4'd1; m_tk = 4'd1; m_st = 4'd2;
        check_cnts("haz");

        // flush mid-wait, then a 3-cycle wait must not trip the watchdog
        do_reset();
        drive(1'b1, 3'd1, 32'h0000_3000, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        check("fl.wait.stall", 32'(stall), 32'h1);
        tick();
        drive(1'b1, 3'd1, 32'h0000_3000, 16'h0004, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        check("fl.stall", 32'(stall), 32'h0);
        check("fl.redirect", 32'(redirect), 32'h0);
        check("fl.cmp_op", 32'(cmp_op), 32'h0);
        tick();
        m_st = 4'd1;
        check_cnts("fl");
        drive(1'b1, 3'd1, 32'h0000_3000, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) tick();
        check("fl.restart.hang_err", 32'(hang_err), 32'h0);
        idle();
        tick();

        // watchdog with MAX_STALL=4
        do_reset();
        drive(1'b1, 3'd2, 32'h0000_5000, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("wd%0d.hang_err", k), 32'(hang_err), (k >= 4) ? 32'h1 : 32'h0);
        end
        rs_ready = 1'b1;
        #1;
        check("wd.res.stall", 32'(stall), 32'h0);
        check("wd.res.cmp_op", 32'(cmp_op), 32'h2);
        tick();
        idle();
        check("wd.after.hang_err", 32'(hang_err), 32'h1);
        m_br = 4'd1; m_tk = 4'd0; m_st = 4'd6;
        check_cnts("wd");
        tick();
        check("wd.sticky.hang_err", 32'(hang_err), 32'h1);
        do_reset();
        check("wd.rst.hang_err", 32'(hang_err), 32'h0);

        // reset during a stall restarts the wait count and clears the counters
        drive(1'b1, 3'd1, 32'h0000_6000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rstw.comb.stall", 32'(stall), 32'h1);
        tick();
        reset = 1'b0;
        m_br = '0; m_tk = '0; m_st = '0;
        check_cnts("rstw");
        check("rstw.hang_err", 32'(hang_err), 32'h0);
        repeat (3) tick();
        check("rstw.w3.hang_err", 32'(hang_err), 32'h0);
        tick();
        check("rstw.w4.hang_err", 32'(hang_err), 32'h1);

        // counter wrap with PERF_W=4
        do_reset();
        drive(1'b1, 3'd1, 32'h0000_7000, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (15) tick();
        check("wrap15.br_cnt", 32'(br_cnt), 32'd15);
        check("wrap15.taken_cnt", 32'(taken_cnt), 32'd15);
        tick();
        check("wrap16.br_cnt", 32'(br_cnt), 32'd0);
        check("wrap16.taken_cnt", 32'(taken_cnt), 32'd0);
        check("wrap16.stall_cnt", 32'(stall_cnt), 32'd0);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
